// File: rtl/ram_autoconfig_multi.sv
// Zorro II autoconfig fast-RAM controller presenting NUM_BANKS equal-sized banks
// as consecutive autoconfig boards in the $E80000 config space.
//
// Ports:
//   CLK, RESET        - 7 MHz CPU clock, synchronous active-high reset
//   _AS, _UDS, R_W    - 68000 bus strobes
//   A[23:1]           - CPU address
//   D_IN / D_OUT      - D[15:12] write data / autoconfig read nibble
//   D_OE              - drive D[15:12]
//   _CONFIGIN         - low when the previous board in the chain is configured
//   _CONFIGOUT        - low once every bank is configured or shut up
//   RAM_CE            - per-bank chip enable
//   DTACK_RANGE       - this cycle belongs to the block
//   CONFIGURED        - per-bank valid base address flag
module ram_autoconfig_multi #(
  parameter int unsigned NUM_BANKS = 2,
  parameter logic [2:0]  SIZE_CODE = 3'b110,
  parameter logic [7:0]  PRODUCT   = 8'h01,
  parameter logic [15:0] MANUF     = 16'h07DB
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 _AS,
  input  logic                 _UDS,
  input  logic                 R_W,
  input  logic [23:1]          A,
  input  logic [3:0]           D_IN,
  output logic [3:0]           D_OUT,
  output logic                 D_OE,
  input  logic                 _CONFIGIN,
  output logic                 _CONFIGOUT,
  output logic [NUM_BANKS-1:0] RAM_CE,
  output logic                 DTACK_RANGE,
  output logic [NUM_BANKS-1:0] CONFIGURED
);

  localparam logic [2:0] NumBanksC = 3'(NUM_BANKS);
  localparam logic [2:0] LastBank  = 3'(NUM_BANKS - 1);

  // Bits of base A[23:19] that take part in the bank match for each size code.
  localparam logic [4:0] BankMask = (SIZE_CODE == 3'b100) ? 5'b11111 :
                                    (SIZE_CODE == 3'b101) ? 5'b11110 :
                                    (SIZE_CODE == 3'b110) ? 5'b11100 : 5'b11000;

  localparam logic [7:0] ProductN = ~PRODUCT;
  localparam logic [15:0] ManufN  = ~MANUF;

  logic [2:0]           cur_q;
  logic [4:0]           base_q [NUM_BANKS];
  logic [NUM_BANKS-1:0] cfg_q;
  logic                 wdone_q;
  logic                 lo_a19_q;
  logic                 configout_q;

  logic                 cfg_sel;
  logic                 rd_acc;
  logic                 wr_acc;
  logic                 in_window;
  logic [3:0]           rd_nibble;
  logic [NUM_BANKS-1:0] ram_ce;

  logic unused_a;
  assign unused_a = ^A[15:7];

  assign cfg_sel = ~_AS & (A[23:16] == 8'hE8) & ~_CONFIGIN & (cur_q < NumBanksC);
  assign rd_acc  = cfg_sel & R_W & ~_UDS;
  assign wr_acc  = cfg_sel & ~R_W & ~_UDS & ~wdone_q;

  // Fast RAM is only decoded inside the Zorro II $200000..$9FFFFF window.
  assign in_window = (A[23:20] >= 4'h2) & (A[23:20] <= 4'h9);

  always_comb begin
    rd_nibble = 4'hF;
    case (A[6:1])
      6'h00: rd_nibble = 4'b1110;
      6'h01: rd_nibble = {cur_q != LastBank, SIZE_CODE};
      6'h02: rd_nibble = ProductN[7:4];
      6'h03: rd_nibble = ProductN[3:0];
      6'h08: rd_nibble = ManufN[15:12];
      6'h09: rd_nibble = ManufN[11:8];
      6'h0A: rd_nibble = ManufN[7:4];
      6'h0B: rd_nibble = ManufN[3:0];
      6'h20: rd_nibble = 4'h0;
      6'h21: rd_nibble = 4'h0;
      default: rd_nibble = 4'hF;
    endcase
  end

  always_comb begin
    ram_ce = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      ram_ce[i] = cfg_q[i] & ~_AS & in_window &
                  ((A[23:19] & BankMask) == (base_q[i] & BankMask));
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cur_q       <= 3'd0;
      cfg_q       <= '0;
      wdone_q     <= 1'b0;
      lo_a19_q    <= 1'b0;
      configout_q <= 1'b1;
      for (int unsigned i = 0; i < NUM_BANKS; i++) begin
        base_q[i] <= 5'd0;
      end
    end else begin
      configout_q <= (cur_q != NumBanksC);
      if (_AS) begin
        wdone_q <= 1'b0;
      end else if (wr_acc) begin
        // One write per bus cycle, however long the CPU holds it.
        wdone_q <= 1'b1;
        case (A[6:1])
          6'h25: lo_a19_q <= D_IN[3];
          6'h24: begin
            for (int unsigned i = 0; i < NUM_BANKS; i++) begin
              if (cur_q == 3'(i)) begin
                base_q[i] <= {D_IN, lo_a19_q};
                cfg_q[i]  <= 1'b1;
              end
            end
            cur_q <= cur_q + 3'd1;
          end
          6'h26: begin
            for (int unsigned i = 0; i < NUM_BANKS; i++) begin
              if (cur_q == 3'(i)) begin
                cfg_q[i] <= 1'b0;
              end
            end
            cur_q <= cur_q + 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign D_OE        = rd_acc;
  assign D_OUT       = rd_acc ? rd_nibble : 4'hF;
  assign RAM_CE      = ram_ce;
  assign DTACK_RANGE = cfg_sel | (|ram_ce);
  assign CONFIGURED  = cfg_q;
  assign _CONFIGOUT  = configout_q;

endmodule

// File: tb/tb_ram_autoconfig_multi.sv
module tb_ram_autoconfig_multi;

  localparam int          NB   = 2;
  localparam logic [2:0]  SZ   = 3'b110;
  localparam logic [7:0]  PROD = 8'h01;
  localparam logic [15:0] MAN  = 16'h07DB;

  logic          clk = 1'b0;
  logic          reset, as_n, uds_n, r_w, cfgin_n;
  logic [23:1]   a;
  logic [3:0]    d_in, d_out;
  logic          d_oe, cfgout_n, dtack;
  logic [NB-1:0] ram_ce, configured;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  always #10 clk = ~clk;

  ram_autoconfig_multi #(
    .NUM_BANKS(NB),
    .SIZE_CODE(SZ),
    .PRODUCT  (PROD),
    .MANUF    (MAN)
  ) dut (
    .CLK        (clk),
    .RESET      (reset),
    ._AS        (as_n),
    ._UDS       (uds_n),
    .R_W        (r_w),
    .A          (a),
    .D_IN       (d_in),
    .D_OUT      (d_out),
    .D_OE       (d_oe),
    ._CONFIGIN  (cfgin_n),
    ._CONFIGOUT (cfgout_n),
    .RAM_CE     (ram_ce),
    .DTACK_RANGE(dtack),
    .CONFIGURED (configured)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_cur;
  int m_base [NB];
  bit m_cfg  [NB];
  bit m_wdone, m_lo, m_cfgout;

  function automatic int bus_addr();
    return int'({a, 1'b0});
  endfunction

  function automatic bit m_sel();
    return !as_n && ((bus_addr() >> 16) == 'hE8) && !cfgin_n && (m_cur < NB);
  endfunction

  function automatic logic [3:0] m_rd(input int off);
    logic [7:0]  p;
    logic [15:0] mf;
    p  = ~PROD;
    mf = ~MAN;
    case (off)
      'h00: return 4'b1110;
      'h02: return {(m_cur != NB - 1), SZ};
      'h04: return p[7:4];
      'h06: return p[3:0];
      'h10: return mf[15:12];
      'h12: return mf[11:8];
      'h14: return mf[7:4];
      'h16: return mf[3:0];
      'h40, 'h42: return 4'h0;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [NB-1:0] m_ce();
    logic [NB-1:0] ce;
    int addr, size;
    addr = bus_addr();
    size = 'h80000 << (int'(SZ) - 4);
    ce = '0;
    for (int i = 0; i < NB; i++)
      ce[i] = m_cfg[i] && !as_n && (addr / size == m_base[i] / size) &&
              addr >= 'h200000 && addr <= 'h9FFFFF;
    return ce;
  endfunction

  always @(posedge clk) begin
    int off;
    if (reset) begin
      m_cur = 0; m_wdone = 0; m_lo = 0; m_cfgout = 1;
      for (int i = 0; i < NB; i++) begin
        m_base[i] = 0;
        m_cfg[i]  = 0;
      end
    end else begin
      m_cfgout = (m_cur != NB);
      off = bus_addr() % 128;
      if (as_n) m_wdone = 0;
      else if (m_sel() && !uds_n && !r_w && !m_wdone) begin
        m_wdone = 1;
        if (off == 'h4A) m_lo = d_in[3];
        else if (off == 'h48) begin
          m_base[m_cur] = int'(d_in) * 'h100000 + int'(m_lo) * 'h80000;
          m_cfg[m_cur]  = 1;
          m_cur++;
        end else if (off == 'h4C) begin
          m_cfg[m_cur] = 0;
          m_cur++;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [NB-1:0] ce, cf;
    bit rd;
    if (cmp_en) begin
      ce = m_ce();
      rd = m_sel() && r_w && !uds_n;
      for (int i = 0; i < NB; i++) cf[i] = m_cfg[i];
      chk("cmp D_OE", 16'(d_oe), 16'(rd));
      chk("cmp D_OUT", 16'(d_out), rd ? 16'(m_rd(bus_addr() % 128)) : 16'hF);
      chk("cmp RAM_CE", 16'(ram_ce), 16'(ce));
      chk("cmp DTACK_RANGE", 16'(dtack), 16'(m_sel() || (|ce)));
      chk("cmp CONFIGURED", 16'(configured), 16'(cf));
      chk("cmp _CONFIGOUT", 16'(cfgout_n), 16'(m_cfgout));
    end
  end

  // ---------------- stimulus ----------------
  task automatic bus(input logic as, input logic uds, input logic rw,
                     input logic [31:0] addr, input logic [3:0] d);
    @(posedge clk); #1;
    as_n = as; uds_n = uds; r_w = rw; a = addr[23:1]; d_in = d;
  endtask

  task automatic idle();
    bus(1'b1, 1'b1, 1'b1, 32'h0, 4'h0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] d);
    bus(1'b0, 1'b0, 1'b0, addr, d);
    idle();
  endtask

  task automatic rd(input logic [31:0] addr);
    bus(1'b0, 1'b0, 1'b1, addr, 4'h0);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1; as_n = 1'b1; uds_n = 1'b1; r_w = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; as_n = 1'b1; uds_n = 1'b1; r_w = 1'b1;
    cfgin_n = 1'b0; a = '0; d_in = 4'h0;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("reset CONFIGURED", 16'(configured), 16'h0);
    chk("reset _CONFIGOUT", 16'(cfgout_n), 16'h1);
    chk("reset D_OE", 16'(d_oe), 16'h0);
    chk("reset D_OUT", 16'(d_out), 16'hF);
    chk("reset RAM_CE", 16'(ram_ce), 16'h0);
    chk("reset DTACK_RANGE", 16'(dtack), 16'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Config ROM of bank 0
    rd(32'hE80000);
    chk("rd00 D_OUT", 16'(d_out), 16'hE);
    chk("rd00 D_OE", 16'(d_oe), 16'h1);
    chk("rd00 DTACK_RANGE", 16'(dtack), 16'h1);
    rd(32'hE80002);
    chk("rd02 D_OUT", 16'(d_out), 16'hE);
    rd(32'hE80012);
    chk("rd12 D_OUT", 16'(d_out), 16'h8);
    for (int off = 0; off < 64; off++) rd(32'hE80000 + 32'(2 * off));
    idle();

    // Bank 0 at $200000
    wr(32'hE8004A, 4'h0);
    wr(32'hE80048, 4'h2);
    @(negedge clk);
    chk("b0 CONFIGURED", 16'(configured), 16'h1);
    rd(32'hE80002);
    chk("b1 rd02 D_OUT", 16'(d_out), 16'h6);
    rd(32'h234566);
    chk("b0 RAM_CE", 16'(ram_ce), 16'h1);
    rd(32'h400000);
    chk("b0 miss RAM_CE", 16'(ram_ce), 16'h0);
    idle();

    // Bank 1 at $400000, chain completes
    wr(32'hE80048, 4'h4);
    @(negedge clk);
    chk("b1 _CONFIGOUT early", 16'(cfgout_n), 16'h1);
    chk("b1 CONFIGURED", 16'(configured), 16'h3);
    @(negedge clk);
    chk("b1 _CONFIGOUT", 16'(cfgout_n), 16'h0);
    rd(32'h4ABCDE);
    chk("b1 RAM_CE", 16'(ram_ce), 16'h2);
    rd(32'hE80000);
    chk("done D_OE", 16'(d_oe), 16'h0);
    idle();

    // Shut-up bank 0, bank 1 at $200000
    pulse_reset();
    wr(32'hE8004C, 4'h0);
    wr(32'hE80048, 4'h2);
    @(negedge clk);
    chk("shutup CONFIGURED", 16'(configured), 16'h2);
    rd(32'h200000);
    chk("shutup RAM_CE", 16'(ram_ce), 16'h2);
    idle();

    // Write held for 5 edges counts once
    pulse_reset();
    bus(1'b0, 1'b0, 1'b0, 32'hE80048, 4'h3);
    repeat (4) @(posedge clk);
    idle();
    @(negedge clk);
    chk("held CONFIGURED", 16'(configured), 16'h1);
    rd(32'hE80002);
    chk("held rd02 D_OUT", 16'(d_out), 16'h6);
    rd(32'h3FFFFE);
    chk("held RAM_CE", 16'(ram_ce), 16'h1);
    idle();

    // Reset after bank 0 configured
    pulse_reset();
    @(negedge clk);
    chk("rst CONFIGURED", 16'(configured), 16'h0);
    chk("rst _CONFIGOUT", 16'(cfgout_n), 16'h1);
    rd(32'h200000);
    chk("rst RAM_CE", 16'(ram_ce), 16'h0);
    rd(32'hE80002);
    chk("rst rd02 D_OUT", 16'(d_out), 16'hE);
    idle();

    // Reset in the middle of a write: discarded, then accepted once afterwards
    @(posedge clk); #1;
    reset = 1'b1; as_n = 1'b0; uds_n = 1'b0; r_w = 1'b0; a = 23'(32'hE80048 >> 1); d_in = 4'h4;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    idle();
    @(negedge clk);
    chk("midrst CONFIGURED", 16'(configured), 16'h1);
    rd(32'h400000);
    chk("midrst RAM_CE", 16'(ram_ce), 16'h1);
    idle();

    // _CONFIGIN high hides the block
    @(posedge clk); #1;
    cfgin_n = 1'b1;
    rd(32'hE80000);
    chk("cfgin D_OE", 16'(d_oe), 16'h0);
    chk("cfgin DTACK_RANGE", 16'(dtack), 16'h0);
    idle();
    wr(32'hE80048, 4'h6);
    @(negedge clk);
    chk("cfgin CONFIGURED", 16'(configured), 16'h1);
    @(posedge clk); #1;
    cfgin_n = 1'b0;

    // Bank 1 above the Zorro II window never decodes
    wr(32'hE80048, 4'hA);
    @(negedge clk);
    chk("hi CONFIGURED", 16'(configured), 16'h3);
    rd(32'hA00000);
    chk("hi RAM_CE", 16'(ram_ce), 16'h0);
    chk("hi DTACK_RANGE", 16'(dtack), 16'h0);
    rd(32'h5FFFFE);
    chk("hi b0 RAM_CE", 16'(ram_ce), 16'h1);
    idle();
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
